// File: rtl/text_fetch_pkg.sv
// Shared geometry constants, FSM state type and the cell address helper for the text fetch stage.
package text_fetch_pkg;

  localparam int FONT_W   = 8;
  localparam int FONT_H   = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int DEF_COLS = SCREEN_W / FONT_W;
  localparam int DEF_ROWS = SCREEN_H / FONT_H;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Row-major linear cell index; out-of-range inputs wrap, callers mask them with their own range check.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [6:0] row,
                                                  input int cols);
    int lin;
    lin = int'(row) * cols + int'(col);
    return lin[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character store: one write port, one registered read port, read-first on collision.
// Storage is deliberately unreset so it maps onto block RAM.
module text_ram #(
  parameter int addr_width = 13,
  parameter int data_width = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [0:(2**addr_width)-1];
  logic [data_width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_fetch.sv
// Maps scan position to the character cell under it, 2-cycle fixed latency, never stalls.
// Host writes use valid/ready; wr_ready is low while the clear sequencer owns the RAM write port.
module text_fetch
  import text_fetch_pkg::*;
#(
  parameter int          COLS       = DEF_COLS,
  parameter int          ROWS       = DEF_ROWS,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20,
  parameter logic [7:0]  BLANK_CHAR = 8'h00
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  logic        video_on_i,
  output logic [9:0]  pos_x_o,
  output logic [9:0]  pos_y_o,
  output logic        video_on_o,
  output logic [7:0]  character,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_col,
  input  logic [5:0]  wr_row,
  input  logic [7:0]  wr_char,
  input  logic        clr_req,
  output logic        busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                busy_q;
  logic                wr_ready_q;

  logic [6:0]          col_d;
  logic [6:0]          row_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                in_range_d;

  logic [ADDR_W-1:0]   addr1_q;
  logic                in_range1_q;
  logic                in_range2_q;
  logic [9:0]          x1_q, y1_q, x2_q, y2_q;
  logic                vid1_q, vid2_q;

  logic                wr_accept;
  logic                wr_in_range;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  // Read pipeline stage 1: cell lookup.
  assign col_d      = pos_x_i[9:3];
  assign row_d      = pos_y_i[9:3];
  assign addr_d     = cell_addr(col_d, row_d, COLS);
  assign in_range_d = (int'(col_d) < COLS) && (int'(row_d) < ROWS);

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      addr1_q     <= '0;
      in_range1_q <= 1'b0;
      in_range2_q <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      vid1_q      <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      vid2_q      <= 1'b0;
    end else begin
      addr1_q     <= addr_d;
      in_range1_q <= in_range_d;
      x1_q        <= pos_x_i;
      y1_q        <= pos_y_i;
      vid1_q      <= video_on_i;
      in_range2_q <= in_range1_q;
      x2_q        <= x1_q;
      y2_q        <= y1_q;
      vid2_q      <= vid1_q;
    end
  end

  assign pos_x_o    = x2_q;
  assign pos_y_o    = y2_q;
  assign video_on_o = vid2_q;
  assign character  = in_range2_q ? ram_rdata : BLANK_CHAR;

  // A clear request in the same cycle pre-empts the host write.
  assign wr_accept   = wr_valid && wr_ready_q && !clr_req;
  assign wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = CLEAR_CHAR;
    if (state_q == ST_CLEAR) begin
      ram_we = 1'b1;
    end else begin
      ram_we    = wr_accept && wr_in_range;
      ram_waddr = cell_addr(wr_col, {1'b0, wr_row}, COLS);
      ram_wdata = wr_char;
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_req) begin
            clr_cnt_q <= '0;
          end else if (clr_cnt_q == LAST_CELL) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_cnt_q  <= '0;
          busy_q     <= 1'b1;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;

  text_ram #(
    .addr_width(ADDR_W),
    .data_width(DATA_W)
  ) u_ram (
    .clk_i  (px_clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(addr1_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_text_fetch.sv
// Directed bench for text_fetch: scan expectations queue up as they are driven and are checked
// when the 2-cycle pipeline delivers them.
module tb_text_fetch;

  logic       px_clk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] pos_x_i = 10'd0;
  logic [9:0] pos_y_i = 10'd0;
  logic       video_on_i = 1'b0;
  logic [9:0] pos_x_o, pos_y_o;
  logic       video_on_o;
  logic [7:0] character;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_col = 7'd0;
  logic [5:0] wr_row = 6'd0;
  logic [7:0] wr_char = 8'h00;
  logic       clr_req = 1'b0;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         chk;
    logic [7:0] ch;
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
  } exp_t;

  exp_t sb[$];

  text_fetch dut (
    .px_clk    (px_clk),
    .reset     (reset),
    .pos_x_i   (pos_x_i),
    .pos_y_i   (pos_y_i),
    .video_on_i(video_on_i),
    .pos_x_o   (pos_x_o),
    .pos_y_o   (pos_y_o),
    .video_on_o(video_on_o),
    .character (character),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_char   (wr_char),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 px_clk = ~px_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: retire the entry driven two cycles ago, then drive the next position.
  task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic v, input bit chk,
                     input logic [7:0] ch);
    exp_t e;
    @(negedge px_clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("character", {24'd0, character}, {24'd0, e.ch});
        check("pos_vid", {11'd0, pos_x_o, pos_y_o, video_on_o}, {11'd0, e.x, e.y, e.v});
      end
    end
    pos_x_i    = x;
    pos_y_i    = y;
    video_on_i = v;
    sb.push_back('{chk, ch, x, y, v});
  endtask

  task automatic idle();
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic scan(input int col, input int row, input logic [7:0] exp);
    logic [9:0] x, y;
    x = 10'(col * 8 + int'($urandom_range(0, 7)));
    y = 10'(row * 8 + int'($urandom_range(0, 7)));
    cyc(x, y, 1'b1, 1'b1, exp);
  endtask

  task automatic host_write(input logic [6:0] col, input logic [5:0] row, input logic [7:0] ch);
    check("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_col   = col;
    wr_row   = row;
    wr_char  = ch;
    idle();
    wr_valid = 1'b0;
  endtask

  // Counts busy-high cycles until the clear completes, plus any handshakes seen meanwhile.
  task automatic measure_clear(input string tag, output int acc);
    int cnt;
    cnt = 0;
    acc = 0;
    while (busy === 1'b1 && cnt < 6000) begin
      cnt++;
      if (wr_valid && wr_ready) acc++;
      idle();
    end
    check(tag, cnt, 32'd4800);
    check("busy_after_clear", {31'd0, busy}, 32'd0);
    check("wr_ready_after_clear", {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    int acc;

    // Reset values with live-looking inputs.
    pos_x_i    = 10'd123;
    pos_y_i    = 10'd45;
    video_on_i = 1'b1;
    repeat (3) @(negedge px_clk);
    check("rst_pos_x", {22'd0, pos_x_o}, 32'd0);
    check("rst_pos_y", {22'd0, pos_y_o}, 32'd0);
    check("rst_video", {31'd0, video_on_o}, 32'd0);
    check("rst_char", {24'd0, character}, 32'h00);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    measure_clear("first_clear_len", acc);

    // Whole text area reads the clear code.
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        scan(c, r, 8'h20);

    host_write(7'd5, 6'd2, 8'h41);
    cyc(10'd43, 10'd17, 1'b1, 1'b1, 8'h41);
    scan(5, 2, 8'h41);
    scan(6, 2, 8'h20);
    scan(4, 2, 8'h20);
    scan(5, 3, 8'h20);

    // Outside the text area and video_on passthrough.
    cyc(10'd700, 10'd100, 1'b1, 1'b1, 8'h00);
    cyc(10'd700, 10'd100, 1'b0, 1'b1, 8'h00);
    cyc(10'd300, 10'd480, 1'b1, 1'b1, 8'h00);
    cyc(10'd639, 10'd479, 1'b1, 1'b1, 8'h20);
    cyc(10'd640, 10'd0,   1'b0, 1'b1, 8'h00);
    cyc(10'd1023, 10'd1023, 1'b1, 1'b1, 8'h00);

    // Out-of-range column write is accepted but must not alias onto another cell.
    host_write(7'd90, 6'd2, 8'h5A);
    host_write(7'd79, 6'd60, 8'h5B);
    scan(0, 0, 8'h20);
    scan(79, 59, 8'h20);
    scan(10, 2, 8'h20);
    scan(10, 3, 8'h20);
    scan(0, 60 - 59, 8'h20);
    idle();
    idle();

    // Clear beats a simultaneous write; a held write waits until the clear ends.
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_col   = 7'd1;
    wr_row   = 6'd1;
    wr_char  = 8'h66;
    idle();
    clr_req = 1'b0;
    check("busy_after_clr_req", {31'd0, busy}, 32'd1);
    check("wr_ready_after_clr_req", {31'd0, wr_ready}, 32'd0);
    wr_col  = 7'd3;
    wr_row  = 6'd4;
    wr_char = 8'h55;
    acc = 0;
    for (int k = 0; k < 2000; k++) begin
      if (wr_valid && wr_ready) acc++;
      idle();
    end
    clr_req = 1'b1;
    idle();
    clr_req = 1'b0;
    begin
      int acc2;
      measure_clear("restarted_clear_len", acc2);
      acc += acc2;
    end
    check("no_accept_while_busy", acc, 32'd0);
    idle();
    wr_valid = 1'b0;
    scan(3, 4, 8'h55);
    scan(2, 4, 8'h20);
    scan(3, 5, 8'h20);
    scan(1, 1, 8'h20);

    // Asynchronous reset in the middle of a clear and an active scan.
    clr_req = 1'b1;
    scan(3, 4, 8'h55);
    clr_req = 1'b0;
    scan(3, 4, 8'h55);
    scan(3, 4, 8'h55);
    scan(3, 4, 8'h55);
    check("pre_reset_char", {24'd0, character}, 32'h55);
    check("pre_reset_video", {31'd0, video_on_o}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pos_x", {22'd0, pos_x_o}, 32'd0);
    check("async_rst_pos_y", {22'd0, pos_y_o}, 32'd0);
    check("async_rst_video", {31'd0, video_on_o}, 32'd0);
    check("async_rst_char", {24'd0, character}, 32'h00);
    check("async_rst_busy", {31'd0, busy}, 32'd1);
    sb.delete();
    repeat (2) @(negedge px_clk);
    reset = 1'b0;
    measure_clear("post_reset_clear_len", acc);
    scan(3, 4, 8'h20);
    scan(5, 2, 8'h20);
    scan(79, 59, 8'h20);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_fetch.md
Name: text_fetch

Overview:
- Character-cell fetch stage that sits directly upstream of the glyph renderer.
- Holds the screen text buffer (COLS x ROWS cells, one 8-bit character code per cell) and maps the incoming scan position to the character under it.
- Emits that character together with pixel position and video-active, delayed by a matching amount so all three stay aligned for the glyph renderer.
- Provides a host write port with valid/ready handshake and a screen-clear sequencer.

Parameters:
- COLS, 80, character columns (640 px / 8).
- ROWS, 60, character rows (480 px / 8).
- CLEAR_CHAR, 8'h20, code written to every cell by a clear.
- BLANK_CHAR, 8'h00, code emitted for positions outside the text area.

Ports:
- px_clk  in  1  pixel clock; only clock.
- reset  in  1  asynchronous, active-high reset.
- pos_x_i  in  10  scan X position.
- pos_y_i  in  10  scan Y position.
- video_on_i  in  1  active-video flag for pos_x_i/pos_y_i.
- pos_x_o  out  10  pos_x_i delayed 2 cycles.
- pos_y_o  out  10  pos_y_i delayed 2 cycles.
- video_on_o  out  1  video_on_i delayed 2 cycles.
- character  out  8  character code for pos_x_o/pos_y_o.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write port can accept.
- wr_col  in  7  target column.
- wr_row  in  6  target row.
- wr_char  in  8  code to store.
- clr_req  in  1  single-cycle clear request.
- busy  out  1  clear in progress.

Behaviour:
- Reset is asynchronous, active-high, single clock domain (px_clk).
- While reset is asserted:
  - pos_x_o, pos_y_o and video_on_o = 0.
  - character = BLANK_CHAR.
  - wr_ready = 0.
  - FSM forced to CLEAR with clear counter = 0, so busy = 1.
- Read pipeline (runs every cycle, independent of FSM state):
  - Stage 1 registers:
    - cell column = pos_x_i[9:3], cell row = pos_y_i[9:3];
    - address = row*COLS + col, 13 bits, unsigned;
    - in_range = (col < COLS) && (row < ROWS).
  - Stage 2: synchronous RAM read.
  - character = in_range (delayed) ? RAM data : BLANK_CHAR.
  - Fixed latency of 2 cycles from pos_*_i to character and pos_*_o. No stalls.
- FSM has two states: CLEAR and IDLE.
- CLEAR state:
  - Writes CLEAR_CHAR to address clr_cnt, then increments clr_cnt, one cell per cycle.
  - When clr_cnt = COLS*ROWS-1 is written, go to IDLE. A full clear takes 4800 cycles with default parameters.
  - busy = 1 and wr_ready = 0 throughout.
- IDLE state:
  - busy = 0, wr_ready = 1.
  - A write is accepted when wr_valid && wr_ready.
  - An accepted write stores wr_char at wr_row*COLS + wr_col in the same cycle.
  - If wr_col >= COLS or wr_row >= ROWS, the write is accepted and discarded; the RAM is unchanged.
- clr_req handling:
  - In IDLE, clr_req -> CLEAR with clr_cnt = 0.
  - In CLEAR, clr_req restarts from clr_cnt = 0.
  - If clr_req and wr_valid are high together in IDLE, clear wins and the write is not accepted (wr_ready is registered low from the next cycle; the same-cycle write is blocked combinationally).
- Read/write collision (same address, same cycle): read returns the old data (read-first). The display is allowed to show partially cleared content during CLEAR.
- Reset mid-clear restarts the clear from 0.

Decomposition:
- Shared constants include: FONT_W=8, FONT_H=8, SCREEN_W=640, SCREEN_H=480; derived COLS/ROWS defaults come from these.
- One sub-module, text_ram:
  - simple dual-port RAM, 1 write port + 1 registered read port, same clock;
  - parameters addr_width=13, data_width=8;
  - no reset on the storage array.
- FSM, clear counter, address arithmetic and delay line stay in text_fetch.

Test Plan:
- Reset, then wait for the clear to finish:
  - busy = 1 for exactly 4800 cycles after reset release, then busy = 0 and wr_ready = 1.
  - Every in-range position then reads 8'h20.
- Write (col 5, row 2, 8'h41), then scan pos_x=43, pos_y=17:
  - character = 8'h41 two cycles later;
  - pos_x_o = 43, pos_y_o = 17 in the same cycle.
- Scan pos_x=700, pos_y=100 (col 87 >= 80): character = 8'h00; video_on_o mirrors video_on_i delayed 2 cycles.
- Write with wr_col=90: the handshake completes and no cell changes. Check cells (0,0), (79,59) and (10,2) still read 8'h20.
- During a clear:
  - wr_valid held high with 8'h55 -> no acceptance until busy falls; the write then lands exactly once.
  - clr_req at count 2000 -> busy stays high for a further 4800 cycles.
- Assert reset asynchronously mid-clear and mid-scan:
  - outputs drop to reset values immediately, with no clock edge needed;
  - after release, a full 4800-cycle clear runs again.
